history_scheduler: RTL and testbench
====================================

HISTORY_SCHEDULER -- requirements
Module: history_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning write-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning memory address-to-data cycles.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, meaning full-FIFO read-win cycles before a forced write.
REQ-004 SHALL have port clk_50  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port vga_req  in  1  VGA read request, one pixel per cycle.
REQ-007 SHALL have ports vga_x / vga_y  in  10 each  pixel being read.
REQ-008 SHALL have ports wr_req, wr_x, wr_y, wr_data  in  1/10/10/4  write request, held until accepted.
REQ-009 SHALL have port wr_ready  out  1  write accepted this cycle when wr_req=1.
REQ-010 SHALL have ports mem_x, mem_y, mem_we, mem_wdata  out  10/10/1/4  registered shared memory port.
REQ-011 SHALL have port mem_rdata  in  4  memory read data, READ_LATENCY cycles after address.
REQ-012 SHALL have ports rd_valid, rd_x, rd_y, rd_data  out  1/10/10/4  returned pixel history with its tag.
REQ-013 SHALL have ports fifo_count  out  log2(FIFO_DEPTH)+1  occupancy; rd_miss  out  1  forced-write pulse.

Function
REQ-014 Write FIFO SHALL push on wr_req&&wr_ready; wr_ready = (fifo_count<FIFO_DEPTH), combinational.
REQ-015 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 Per cycle, arbiter SHALL pick exactly one: READ if vga_req=1, else WRITE if FIFO non-empty, else IDLE.
REQ-017 READ at edge N: mem_x/mem_y=vga_x/vga_y, mem_we=0 from cycle N+1.
REQ-018 WRITE: FIFO head driven to mem_x/mem_y/mem_wdata with mem_we=1 for one cycle; head popped same edge.
REQ-019 IDLE: mem_we=0, mem_x/mem_y hold previous value.
REQ-020 Tag pipe (valid,x,y) SHALL give rd_valid=1 with rd_x/rd_y of the request exactly 1+READ_LATENCY cycles after vga_req sampled (3 by default).
REQ-021 rd_data SHALL equal mem_rdata when rd_valid=1, else 4'd0.
REQ-022 No write-to-read forwarding: a read returns memory contents, even if a matching write is still queued.
REQ-023 FIFO order SHALL be preserved; no entry lost or duplicated under any vga_req pattern.
REQ-024 Back-to-back reads SHALL sustain one rd_valid per cycle.

Reset
REQ-025 Reset SHALL empty FIFO, clear tag pipe and starvation counter; reset dominates all other activity.
REQ-026 During/after reset: mem_we=0, mem_x=mem_y=0, mem_wdata=0, rd_valid=0, rd_x=rd_y=rd_data=0, fifo_count=0, rd_miss=0.
REQ-027 In-flight reads at reset SHALL be discarded (no rd_valid after reset).

Configuration
REQ-028 Macro HIST_SCHED_STARVE_EN defined: counter increments each cycle FIFO full and vga_req=1, else clears; at STARVE_LIMIT next grant SHALL be WRITE despite vga_req, that read dropped (no rd_valid), rd_miss=1 for that cycle, counter cleared.
REQ-029 Macro undefined: reads always win, rd_miss tied 0, counter not built.

Verification
REQ-030 Reset, then vga_req=1 x=10 y=20 at edge N -> mem_x=10,mem_y=20,mem_we=0 at N+1; rd_valid=1, rd_x=10, rd_y=20 at N+3.
REQ-031 vga_req=0, push (30,40,data 5) -> one cycle later mem_we=1, mem_x=30, mem_y=40, mem_wdata=5; fifo_count returns 0.
REQ-032 vga_req=1 continuous, 9 write requests -> wr_ready low after 8, fifo_count=8; drop vga_req -> 8 writes in push order, then 9th accepted.
REQ-033 Five consecutive reads (10,20)..(90,100) -> five consecutive rd_valid cycles, tags in order, no gaps.
REQ-034 With HIST_SCHED_STARVE_EN, FIFO full and vga_req=1 for 16 cycles -> one forced write, rd_miss pulse, missing rd_valid for that slot; without macro -> no write, rd_miss=0.
REQ-035 Assert reset with 2 reads in flight and 3 queued writes -> no rd_valid, no mem_we afterward, fifo_count=0.

Source files
------------

// File: rtl/history_scheduler.sv
// history_scheduler
//
// Shares one memory port between a VGA pixel-history reader and a queued
// pixel writer. Each cycle exactly one access is granted: a VGA read if one
// is requested, otherwise the oldest queued write, otherwise nothing. Read
// tags ride a (1+READ_LATENCY)-stage pipe, so each returned data nibble
// leaves with the (x,y) it belongs to.
//
// Optional feature (macro HIST_SCHED_STARVE_EN): if the write FIFO sits full
// while reads keep winning for STARVE_LIMIT cycles, one write is forced
// through. The read in that slot is dropped and rd_miss pulses.
//
// Ports
//   clk_50                         system clock, rising edge
//   reset                          synchronous, active-high
//   vga_req, vga_x, vga_y          read request for one pixel per cycle
//   wr_req, wr_x, wr_y, wr_data    write request, held until accepted
//   wr_ready                       write accepted this cycle when wr_req=1
//   mem_x, mem_y, mem_we,
//   mem_wdata                      registered shared memory port
//   mem_rdata                      read data, READ_LATENCY cycles after address
//   rd_valid, rd_x, rd_y, rd_data  returned pixel history with its tag
//   fifo_count                     write FIFO occupancy
//   rd_miss                        pulses when a read slot was given to a forced write
module history_scheduler #(
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic                          vga_req,
  input  logic [9:0]                    vga_x,
  input  logic [9:0]                    vga_y,
  input  logic                          wr_req,
  input  logic [9:0]                    wr_x,
  input  logic [9:0]                    wr_y,
  input  logic [3:0]                    wr_data,
  output logic                          wr_ready,
  output logic [9:0]                    mem_x,
  output logic [9:0]                    mem_y,
  output logic                          mem_we,
  output logic [3:0]                    mem_wdata,
  input  logic [3:0]                    mem_rdata,
  output logic                          rd_valid,
  output logic [9:0]                    rd_x,
  output logic [9:0]                    rd_y,
  output logic [3:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rd_miss
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [9:0]    fifo_x [FIFO_DEPTH];
  logic [9:0]    fifo_y [FIFO_DEPTH];
  logic [3:0]    fifo_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic push;
  logic pop;
  logic fifo_empty;
  logic force_write;
  logic read_grant;
  logic write_grant;

  assign wr_ready   = (fifo_count < FULL_COUNT);
  assign push       = wr_req && wr_ready;
  assign fifo_empty = (fifo_count == '0);

  // Reads normally win; a forced write (starvation relief) overrides them.
  assign read_grant  = vga_req && !force_write;
  assign write_grant = force_write || (!vga_req && !fifo_empty);
  assign pop         = write_grant;

`ifdef HIST_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Only counts while the FIFO is full and blocked by reads; any other
  // cycle, or the forced write itself, restarts the count.
  assign force_write = vga_req && (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk_50) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (force_write) begin
      starve_cnt <= '0;
    end else if (!wr_ready && vga_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      rd_miss <= 1'b0;
    end else begin
      rd_miss <= force_write;
    end
  end
`else
  assign force_write = 1'b0;
  assign rd_miss     = 1'b0;
`endif

  // Storage is not reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk_50) begin
    if (push) begin
      fifo_x[wr_ptr] <= wr_x;
      fifo_y[wr_ptr] <= wr_y;
      fifo_d[wr_ptr] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Memory port: an idle cycle keeps the last address so the RAM sees no
  // spurious address toggling.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      mem_x     <= '0;
      mem_y     <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (write_grant) begin
      mem_x     <= fifo_x[rd_ptr];
      mem_y     <= fifo_y[rd_ptr];
      mem_wdata <= fifo_d[rd_ptr];
      mem_we    <= 1'b1;
    end else if (read_grant) begin
      mem_x  <= vga_x;
      mem_y  <= vga_y;
      mem_we <= 1'b0;
    end else begin
      mem_we <= 1'b0;
    end
  end

  logic       tag_v [READ_LATENCY+1];
  logic [9:0] tag_x [READ_LATENCY+1];
  logic [9:0] tag_y [READ_LATENCY+1];

  // One stage for the registered address plus READ_LATENCY stages for the
  // RAM; the tag lands in the same cycle as the matching mem_rdata.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      tag_v[0] <= read_grant;
      tag_x[0] <= read_grant ? vga_x : 10'd0;
      tag_y[0] <= read_grant ? vga_y : 10'd0;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
    end
  end

  assign rd_valid = tag_v[READ_LATENCY];
  assign rd_x     = tag_x[READ_LATENCY];
  assign rd_y     = tag_y[READ_LATENCY];
  assign rd_data  = rd_valid ? mem_rdata : 4'd0;

endmodule

// File: tb/tb_history_scheduler.sv
module tb_history_scheduler;

  localparam int FIFO_DEPTH   = 8;
  localparam int READ_LATENCY = 2;
  localparam int STARVE_LIMIT = 16;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  logic          clk_50 = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [9:0]    vga_x, vga_y;
  logic          wr_req;
  logic [9:0]    wr_x, wr_y;
  logic [3:0]    wr_data;
  logic          wr_ready;
  logic [9:0]    mem_x, mem_y;
  logic          mem_we;
  logic [3:0]    mem_wdata;
  logic [3:0]    mem_rdata;
  logic          rd_valid;
  logic [9:0]    rd_x, rd_y;
  logic [3:0]    rd_data;
  logic [CW-1:0] fifo_count;
  logic          rd_miss;

  history_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .READ_LATENCY(READ_LATENCY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_50(clk_50), .reset(reset),
    .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .fifo_count(fifo_count), .rd_miss(rd_miss)
  );

  always #10 clk_50 = ~clk_50;

  // Reference model: a queue of pending writes and a queue of outstanding
  // reads, each read stamped with the edge at which its data must return.
  typedef struct { logic [9:0] x; logic [9:0] y; logic [3:0] d; } wr_t;
  typedef struct { int due; logic [9:0] x; logic [9:0] y; } rd_t;

  wr_t wq[$];
  rd_t rq[$];

  int  edge_n;
  int  n_compared;
  int  n_mismatched;
  int  starve;
  bit  known;

  logic [9:0] e_mx, e_my;
  logic       e_we;
  logic [3:0] e_wd;
  logic       e_rv;
  logic [9:0] e_rx, e_ry;
  logic       e_miss;

  bit         pend;
  logic [9:0] p_x, p_y;
  logic [3:0] p_d;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic queueWrite(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
    if (!pend) begin
      pend = 1'b1;
      p_x  = x;
      p_y  = y;
      p_d  = d;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, advance the
  // model, check registered outputs.
  task automatic applyStimulus(input bit rst, input bit vreq, input logic [9:0] vx, input logic [9:0] vy);
    logic [3:0] rdat;
    bit         full;
    bit         accept;
    bit         force_w;
    rdat      = 4'($urandom);
    reset     = rst;
    vga_req   = vreq;
    vga_x     = vx;
    vga_y     = vy;
    wr_req    = pend;
    wr_x      = p_x;
    wr_y      = p_y;
    wr_data   = p_d;
    mem_rdata = rdat;
    #1;
    if (known) begin
      checkOutput("wr_ready", {31'd0, wr_ready}, (wq.size() < FIFO_DEPTH) ? 32'd1 : 32'd0);
      checkOutput("rd_data", {28'd0, rd_data}, e_rv ? {28'd0, rdat} : 32'd0);
    end
    @(posedge clk_50);
    edge_n++;
    if (rst) begin
      wq.delete();
      rq.delete();
      e_mx   = '0;
      e_my   = '0;
      e_we   = 1'b0;
      e_wd   = '0;
      e_miss = 1'b0;
      starve = 0;
      pend   = 1'b0;
      known  = 1'b1;
    end else begin
      full    = (wq.size() == FIFO_DEPTH);
      accept  = pend && !full;
      force_w = 1'b0;
`ifdef HIST_SCHED_STARVE_EN
      force_w = vreq && (starve == STARVE_LIMIT);
      if (force_w || !(full && vreq)) starve = 0;
      else starve++;
`endif
      e_miss = force_w;
      if (force_w || (!vreq && wq.size() > 0)) begin
        wr_t h;
        h    = wq.pop_front();
        e_mx = h.x;
        e_my = h.y;
        e_wd = h.d;
        e_we = 1'b1;
      end else begin
        e_we = 1'b0;
        if (vreq) begin
          e_mx = vx;
          e_my = vy;
          rq.push_back('{edge_n + READ_LATENCY, vx, vy});
        end
      end
      if (accept) begin
        wq.push_back('{p_x, p_y, p_d});
        pend = 1'b0;
      end
    end
    e_rv = 1'b0;
    e_rx = '0;
    e_ry = '0;
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      rd_t r;
      r    = rq.pop_front();
      e_rv = 1'b1;
      e_rx = r.x;
      e_ry = r.y;
    end
    #1;
    checkOutput("mem_x", {22'd0, mem_x}, {22'd0, e_mx});
    checkOutput("mem_y", {22'd0, mem_y}, {22'd0, e_my});
    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    checkOutput("mem_wdata", {28'd0, mem_wdata}, {28'd0, e_wd});
    checkOutput("fifo_count", {{(32-CW){1'b0}}, fifo_count}, wq.size());
    checkOutput("rd_valid", {31'd0, rd_valid}, {31'd0, e_rv});
    checkOutput("rd_miss", {31'd0, rd_miss}, {31'd0, e_miss});
    if (e_rv || rst) begin
      checkOutput("rd_x", {22'd0, rd_x}, {22'd0, e_rx});
      checkOutput("rd_y", {22'd0, rd_y}, {22'd0, e_ry});
    end
  endtask

  initial begin
    int issued;
    n_compared   = 0;
    n_mismatched = 0;
    edge_n       = 0;
    starve       = 0;
    known        = 1'b0;
    pend         = 1'b0;
    p_x = '0; p_y = '0; p_d = '0;
    e_rv = 1'b0;

    // Reset values
    $display("[TB] reset");
    repeat (3) applyStimulus(1'b1, 1'b0, 10'd0, 10'd0);

    // Single read, tag returns three cycles after the request
    $display("[TB] single read");
    applyStimulus(1'b0, 1'b1, 10'd10, 10'd20);
    repeat (4) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    // Single write drains one cycle after push
    $display("[TB] single write");
    queueWrite(10'd30, 10'd40, 4'd5);
    repeat (3) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    // Fill under continuous reads, 9th write waits, then drain in order
    $display("[TB] fill and drain");
    issued = 0;
    for (int i = 0; i < 12; i++) begin
      if (!pend && issued < 9) begin
        queueWrite(10'(100 + issued), 10'(200 + issued), 4'(issued + 1));
        issued++;
      end
      applyStimulus(1'b0, 1'b1, 10'($urandom), 10'($urandom));
    end
    repeat (12) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    // Five back-to-back reads
    $display("[TB] back-to-back reads");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 10'(10 + 20 * i), 10'(20 + 20 * i));
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    // Full FIFO held off by reads long enough to hit the starvation limit
    $display("[TB] starvation window");
    issued = 0;
    for (int i = 0; i < 8 + STARVE_LIMIT + 6; i++) begin
      if (!pend && issued < FIFO_DEPTH) begin
        queueWrite(10'($urandom), 10'($urandom), 4'($urandom));
        issued++;
      end
      applyStimulus(1'b0, 1'b1, 10'($urandom), 10'($urandom));
    end
    repeat (12) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    // Reset with reads in flight and writes queued
    $display("[TB] reset mid-traffic");
    for (int i = 0; i < 3; i++) begin
      queueWrite(10'(300 + i), 10'(400 + i), 4'(9 + i));
      applyStimulus(1'b0, 1'b1, 10'(50 + i), 10'(60 + i));
    end
    repeat (2) applyStimulus(1'b1, 1'b1, 10'd7, 10'd7);
    repeat (6) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    // Randomized traffic, including read-heavy stretches and rare resets
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        queueWrite(10'($urandom), 10'($urandom), 4'($urandom));
      end
      applyStimulus($urandom_range(0, 149) == 0,
                    (i % 200 < 100) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 5),
                    10'($urandom), 10'($urandom));
    end
    repeat (12) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
